// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out stage feeding the 1-bit din input of the serial
// pattern-detector FSMs. A WIDTH-bit word is accepted on a valid/ready
// handshake and shifted out one bit per clock. An optional idle gap of
// GAP_CYCLES cycles follows each word. The final bit of every word is flagged
// on `last`.
//
// Handshake: a word transfers at a posedge where load_valid && load_ready are
// both 1 (load_ready is already forced low while rst==0). load_ready never
// depends on load_valid. Once load_valid is raised, upstream holds it and
// load_data stable until the transfer edge. load_data is sampled only on that
// edge.
//
// Parameters
//   WIDTH       word width in bits (2..32)
//   MSB_FIRST   1: word[WIDTH-1] goes out first, 0: word[0] goes out first
//   GAP_CYCLES  idle cycles inserted after each word (0..15)
//   IDLE_BIT    level on dout whenever no data bit is being driven
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active low
//   load_valid  upstream word valid
//   load_data   upstream word
//   load_ready  combinational: a word can be accepted this cycle
//   dout        registered serial bit (detector din)
//   dout_valid  registered: dout carries a data bit
//   last        registered: dout carries the word's final bit
//   busy        registered: state is SHIFT or GAP
//   dbg_state   current FSM state encoding (0 IDLE, 1 SHIFT, 2 GAP)
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  // Only meaningful when GAP_CYCLES > 0; GAP is unreachable otherwise.
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic          HAS_GAP  = (GAP_CYCLES > 0);

  state_t          r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]   r_bit_cnt;
  logic [3:0]      r_gap_cnt;
  logic            r_dout;
  logic            r_dout_valid;
  logic            r_last;
  logic            r_busy;

  logic            w_load_ready;
  logic            w_xfer;
  logic            w_bit_last;
  logic [CW-1:0]   w_bit_cnt_nxt;

  // Bit that leaves the word next, honouring the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] d);
    if (MSB_FIRST != 0) return d[WIDTH-1];
    else                return d[0];
  endfunction

  // Word with its head bit consumed, so the next bit sits at the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    if (MSB_FIRST != 0) return d << 1;
    else                return d >> 1;
  endfunction

  assign w_bit_last    = (r_bit_cnt == LAST_CNT);
  assign w_bit_cnt_nxt = r_bit_cnt + 1'b1;

  // Accepting during the final bit cycle (gapless only) lets the next word's
  // first bit follow immediately, giving a continuous bitstream.
  assign w_load_ready = rst &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_SHIFT) && w_bit_last && !HAS_GAP));
  assign w_xfer       = load_valid && w_load_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
    end else if (w_xfer) begin
      // The head bit is registered straight onto dout, so it appears the
      // cycle after the handshake; the register keeps the remaining bits.
      r_state      <= ST_SHIFT;
      r_shreg      <= advance(load_data);
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_dout       <= head_bit(load_data);
      r_dout_valid <= 1'b1;
      r_last       <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dout       <= IDLE_BIT;
          r_dout_valid <= 1'b0;
          r_last       <= 1'b0;
          r_busy       <= 1'b0;
        end

        ST_SHIFT: begin
          if (w_bit_last) begin
            r_dout       <= IDLE_BIT;
            r_dout_valid <= 1'b0;
            r_last       <= 1'b0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            if (HAS_GAP) begin
              r_state <= ST_GAP;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_dout       <= head_bit(r_shreg);
            r_shreg      <= advance(r_shreg);
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_dout_valid <= 1'b1;
            r_last       <= (w_bit_cnt_nxt == LAST_CNT);
            r_busy       <= 1'b1;
          end
        end

        ST_GAP: begin
          r_dout       <= IDLE_BIT;
          r_dout_valid <= 1'b0;
          r_last       <= 1'b0;
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
            r_busy    <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_bit_cnt    <= '0;
          r_gap_cnt    <= '0;
          r_dout       <= IDLE_BIT;
          r_dout_valid <= 1'b0;
          r_last       <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = w_load_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign last       = r_last;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Three serializers share clock, reset and the upstream load interface:
//   u_d0  MSB first, no gap
//   u_d1  MSB first, GAP_CYCLES = 3
//   u_d2  LSB first, no gap
// Each scenario task resets all three, drives the shared inputs and checks the
// instance it targets against hand-computed bit sequences.
// Inputs change and outputs are sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;

  logic       d0_ready, d0_dout, d0_dvalid, d0_last, d0_busy;
  logic [1:0] d0_state;
  logic       d1_ready, d1_dout, d1_dvalid, d1_last, d1_busy;
  logic [1:0] d1_state;
  logic       d2_ready, d2_dout, d2_dvalid, d2_last, d2_busy;
  logic [1:0] d2_state;

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(d0_ready), .dout(d0_dout), .dout_valid(d0_dvalid),
    .last(d0_last), .busy(d0_busy), .dbg_state(d0_state)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(3), .IDLE_BIT(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(d1_ready), .dout(d1_dout), .dout_valid(d1_dvalid),
    .last(d1_last), .busy(d1_busy), .dbg_state(d1_state)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(d2_ready), .dout(d2_dout), .dout_valid(d2_dvalid),
    .last(d2_last), .busy(d2_busy), .dbg_state(d2_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    step();
    step();
    checks++;
    if (d0_dout !== 1'b0 || d0_dvalid !== 1'b0 || d0_last !== 1'b0 || d0_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%b dvalid=%b last=%b busy=%b want 0000",
               d0_dout, d0_dvalid, d0_last, d0_busy);
    end
    checks++;
    if (d0_ready !== 1'b0 || d1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: d0=%b d1=%b want 0", d0_ready, d1_ready);
    end
    checks++;
    if (d0_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", d0_state);
    end
    load_valid = 1'b0;
    rst        = 1'b1;
    #1;
    checks++;
    if (d0_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", d0_ready);
    end
    step();
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [4:0] hist;
    int         hits;
    w    = 8'h12;
    hist = 5'b0;
    hits = 0;
    apply_reset();
    load_valid = 1'b1;
    load_data  = w;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (d0_dout !== w[7-i] || d0_dvalid !== 1'b1) begin
        errors++;
        $display("FAIL single_bit%0d: dout=%b dvalid=%b want %b/1", i, d0_dout, d0_dvalid, w[7-i]);
      end
      checks++;
      if (d0_last !== (i == 7)) begin
        errors++;
        $display("FAIL single_last%0d: got %b want %b", i, d0_last, (i == 7));
      end
      if (d0_dvalid) begin
        hist = {hist[3:0], d0_dout};
        if (hist == 5'b10010) hits++;
      end
      step();
    end
    checks++;
    if (d0_dvalid !== 1'b0 || d0_busy !== 1'b0 || d0_dout !== 1'b0) begin
      errors++;
      $display("FAIL single_end: dvalid=%b busy=%b dout=%b want 0/0/0", d0_dvalid, d0_busy, d0_dout);
    end
    checks++;
    if (hits !== 1) begin
      errors++;
      $display("FAIL single_detect: hits=%0d want 1", hits);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    apply_reset();
    load_valid = 1'b1;
    load_data  = 8'hA5;
    checks++;
    if (d0_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_ready: got %b want 1", d0_ready);
    end
    step();
    for (int i = 0; i < 16; i++) begin
      w = (i < 8) ? 8'hA5 : 8'h3C;
      checks++;
      if (d0_dout !== w[7-(i%8)] || d0_dvalid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bit%0d: dout=%b dvalid=%b want %b/1", i, d0_dout, d0_dvalid, w[7-(i%8)]);
      end
      checks++;
      if (d0_ready !== ((i % 8) == 7)) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b want %b", i, d0_ready, ((i % 8) == 7));
      end
      if (i == 7)  load_data  = 8'h3C;
      if (i == 15) load_valid = 1'b0;
      step();
    end
    checks++;
    if (d0_dvalid !== 1'b0 || d0_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: dvalid=%b busy=%b want 0/0", d0_dvalid, d0_busy);
    end
  endtask

  task automatic test_gap();
    apply_reset();
    load_valid = 1'b1;
    load_data  = 8'hFF;
    step();
    load_data = 8'h00;   // next word held pending during the first
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (d1_dout !== 1'b1 || d1_dvalid !== 1'b1 || d1_ready !== 1'b0) begin
        errors++;
        $display("FAIL gap_word1_bit%0d: dout=%b dvalid=%b ready=%b want 1/1/0",
                 i, d1_dout, d1_dvalid, d1_ready);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d1_dout !== 1'b0 || d1_dvalid !== 1'b0 || d1_ready !== 1'b0 || d1_busy !== 1'b1) begin
        errors++;
        $display("FAIL gap_cycle%0d: dout=%b dvalid=%b ready=%b busy=%b want 0/0/0/1",
                 i, d1_dout, d1_dvalid, d1_ready, d1_busy);
      end
      step();
    end
    checks++;
    if (d1_ready !== 1'b1 || d1_busy !== 1'b0 || d1_dvalid !== 1'b0) begin
      errors++;
      $display("FAIL gap_idle: ready=%b busy=%b dvalid=%b want 1/0/0", d1_ready, d1_busy, d1_dvalid);
    end
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (d1_dout !== 1'b0 || d1_dvalid !== 1'b1 || d1_last !== (i == 7)) begin
        errors++;
        $display("FAIL gap_word2_bit%0d: dout=%b dvalid=%b last=%b want 0/1/%b",
                 i, d1_dout, d1_dvalid, d1_last, (i == 7));
      end
      step();
    end
    checks++;
    if (d1_busy !== 1'b1 || d1_dvalid !== 1'b0) begin
      errors++;
      $display("FAIL gap_after_word2: busy=%b dvalid=%b want 1/0", d1_busy, d1_dvalid);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'b1000_0000;  // bit 7 of this vector goes out first
    apply_reset();
    load_valid = 1'b1;
    load_data  = 8'h01;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (d2_dout !== exp_bits[7-i] || d2_dvalid !== 1'b1 || d2_last !== (i == 7)) begin
        errors++;
        $display("FAIL lsb_bit%0d: dout=%b dvalid=%b last=%b want %b/1/%b",
                 i, d2_dout, d2_dvalid, d2_last, exp_bits[7-i], (i == 7));
      end
      step();
    end
    checks++;
    if (d2_dvalid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end: dvalid=%b want 0", d2_dvalid);
    end
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    load_valid = 1'b1;
    load_data  = 8'hF0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d0_dout !== 1'b1 || d0_dvalid !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_bit%0d: dout=%b dvalid=%b want 1/1", i, d0_dout, d0_dvalid);
      end
      if (i == 3) rst = 1'b0;
      step();
    end
    checks++;
    if (d0_dout !== 1'b0 || d0_dvalid !== 1'b0 || d0_busy !== 1'b0 || d0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: dout=%b dvalid=%b busy=%b ready=%b want 0/0/0/0",
               d0_dout, d0_dvalid, d0_busy, d0_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (d0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b want 1", d0_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (d0_dvalid !== 1'b0 || d0_dout !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_residue%0d: dvalid=%b dout=%b want 0/0", i, d0_dvalid, d0_dout);
      end
    end
  endtask

  task automatic test_no_capture();
    logic [7:0] w;
    w = 8'hC3;
    apply_reset();
    load_valid = 1'b1;
    load_data  = w;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (d0_dout !== w[7-i] || d0_dvalid !== 1'b1) begin
        errors++;
        $display("FAIL nocap_bit%0d: dout=%b dvalid=%b want %b/1", i, d0_dout, d0_dvalid, w[7-i]);
      end
      // A one-cycle valid pulse while ready is low must be ignored.
      if (i == 3) begin
        load_valid = 1'b1;
        load_data  = 8'h3C;
      end else begin
        load_valid = 1'b0;
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d0_dvalid !== 1'b0 || d0_busy !== 1'b0) begin
        errors++;
        $display("FAIL nocap_after%0d: dvalid=%b busy=%b want 0/0", i, d0_dvalid, d0_busy);
      end
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_lsb_first();
    test_reset_mid_word();
    test_no_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the serial pattern-detector FSMs and drives their 1-bit `din` input.
- Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock.
- Inserts a programmable idle gap between words and flags each word's last bit.
- Lets benches and upper-level logic feed byte streams into the detectors without hand-toggling `din`.

Parameters:
- WIDTH, default 8: word width in bits (valid range 2..32).
- MSB_FIRST, default 1: 1 = shift MSB first, 0 = LSB first.
- GAP_CYCLES, default 0: idle cycles inserted after each word (valid range 0..15).
- IDLE_BIT, default 0: level driven on dout when no word is being shifted.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low; one clock, no other clock domain.
- load_valid  input  1  upstream word valid.
- load_data  input  WIDTH  upstream word; sampled only on handshake.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit, registered; feeds detector din.
- dout_valid  output  1  1 while dout carries a data bit.
- last  output  1  1 during the cycle dout carries the word's final bit.
- busy  output  1  1 in SHIFT or GAP.

Behaviour:
- Reset: rst==0 at a posedge forces state=IDLE, dout=IDLE_BIT, dout_valid=0, last=0, busy=0, shift register and counters = 0.
  - Applies mid-word or mid-gap too; the word in flight is discarded, with no partial completion.
  - load_ready=0 while rst==0.
- States:
  - IDLE: dout=IDLE_BIT, dout_valid=0.
  - SHIFT: WIDTH cycles, one bit per cycle.
  - GAP: GAP_CYCLES cycles, dout=IDLE_BIT, dout_valid=0.
- Handshake: the transfer occurs at a posedge where load_valid && load_ready && rst==1.
  - load_data is captured into the shift register.
  - bit_cnt is cleared.
  - state goes to SHIFT.
- load_ready is combinational. It is 1 when:
  - state==IDLE, or
  - state==SHIFT && bit_cnt==WIDTH-1 && GAP_CYCLES==0 (back-to-back streaming).
- Latency: the first bit appears on dout the cycle after the handshake edge. Each bit is held exactly one cycle.
  - With GAP_CYCLES=0, consecutive words form a continuous bitstream with no bubble.
- Bit order:
  - MSB_FIRST=1: dout = load_data[WIDTH-1] first, down to [0].
  - MSB_FIRST=0: reverse order.
- last=1 exactly when bit_cnt==WIDTH-1 in SHIFT; it coincides with dout_valid=1.
- End of SHIFT:
  - If GAP_CYCLES>0: go to GAP, gap_cnt=0; after GAP_CYCLES cycles, go to IDLE.
  - Else, if a new handshake happens: stay in SHIFT with the new word.
  - Else: go to IDLE.
- GAP: load_ready=0. Upstream must hold load_valid/load_data stable until the handshake; data is never dropped or duplicated.
- busy=1 in SHIFT or GAP; 0 in IDLE.
- Counters:
  - bit_cnt width = $clog2(WIDTH).
  - gap_cnt is 4 bits.
  - No wrap-around beyond terminal count; both clear on reset and on state entry.
- Unused or illegal state encodings return to IDLE on the next clock with outputs at IDLE values.

Test Plan:
- Reset then load 8'h12, MSB_FIRST=1, GAP=0.
  - dout = 0,0,0,1,0,0,1,0 on cycles 1..8 after the handshake.
  - last=1 on cycle 8 only.
  - A downstream 10010 detector pulses its output once.
- Back-to-back 8'hA5 then 8'h3C, GAP=0, load_valid held high.
  - 16 consecutive dout_valid cycles: 10100101 00111100.
  - load_ready=1 only on IDLE cycle and the cycle with bit_cnt=7.
- GAP_CYCLES=3, two words 8'hFF, 8'h00.
  - 8 ones, then 3 cycles dout=IDLE_BIT with dout_valid=0 and load_ready=0, then 8 zeros.
  - Second word accepted on the first IDLE cycle.
- MSB_FIRST=0, load 8'h01 → dout = 1,0,0,0,0,0,0,0.
- rst=0 asserted at bit 4 of 8'hF0.
  - The next cycle has dout=IDLE_BIT, dout_valid=0, busy=0.
  - After release, load_ready=1 and no remaining bits of 8'hF0 appear.
- load_valid pulsed during SHIFT while load_ready=0 → no capture; output stream of the current word unchanged.
